// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the 3x3 convolution sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    RUN,
    DRAIN,
    DONE
  } conv_ctrl_state_t;

  // Valid output extent of a 3x3 window sliding over an input of size in.
  function automatic int out_dim(input int in);
    return in - 2;
  endfunction

  // Counter width for an index in 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv33_pos_cnt.sv
// Row/col raster position counter for the output pixel grid.
module conv33_pos_cnt
  import conv_ctrl_pkg::*;
#(
  parameter int ROWS = 26,
  parameter int COLS = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic wrap,
  output logic last
);

  localparam int RW = cnt_width(ROWS);
  localparam int CW = cnt_width(COLS);

  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;

  // wrap: at the final column; last: on the final row.
  assign wrap = (col_reg == CW'(COLS - 1));
  assign last = (row_reg == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clr) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (inc) begin
      if (wrap) begin
        col_reg <= '0;
        row_reg <= last ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv33_ctrl.sv
// Sequencer for the 3x3 conv datapath: per channel, load weights, issue every
// window, then drain the calc stage before moving to the next channel.
module conv33_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int C_OUT      = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CH_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  w_req,
  output logic [CH_WIDTH-1:0]   w_ch,
  input  logic                  w_ack,
  input  logic                  win_valid,
  output logic                  win_ready,
  output logic                  conv33_en,
  input  logic                  calc_valid,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int OW = out_dim(IMG_W);
  localparam int OH = out_dim(IMG_H);

  conv_ctrl_state_t state_reg, state_next;
  logic [CH_WIDTH-1:0]   ch_reg;
  logic [1:0]            outst_reg, outst_next;
  logic [ADDR_WIDTH-1:0] addr_reg;

  logic issue, accept, start_acc, drain_exit, ch_last;
  logic pos_wrap, pos_last;

  assign issue      = (state_reg == RUN) && win_valid;
  // A calc_valid with nothing in flight is stray and must not underflow.
  assign accept     = calc_valid && (outst_reg != 2'd0);
  assign start_acc  = (state_reg == IDLE) && start;
  assign ch_last    = (ch_reg == CH_WIDTH'(C_OUT - 1));
  // Uses the post-update count so a result returning this cycle releases DRAIN.
  assign drain_exit = (state_reg == DRAIN) && (outst_next == 2'd0);

  conv33_pos_cnt #(
    .ROWS (OH),
    .COLS (OW)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .inc  (issue),
    .wrap (pos_wrap),
    .last (pos_last)
  );

  always_comb begin
    outst_next = outst_reg;
    if (issue && !accept)
      outst_next = outst_reg + 2'd1;
    else if (accept && !issue)
      outst_next = outst_reg - 2'd1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD_W;
      LOAD_W:  if (w_ack) state_next = RUN;
      RUN:     if (issue && pos_wrap && pos_last) state_next = DRAIN;
      DRAIN:   if (drain_exit) state_next = ch_last ? DONE : LOAD_W;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      outst_reg <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      outst_reg <= outst_next;
      if (start_acc)
        ch_reg <= '0;
      else if (drain_exit && !ch_last)
        ch_reg <= ch_reg + 1'b1;
      if (start_acc)
        addr_reg <= '0;
      else if (accept)
        addr_reg <= addr_reg + 1'b1;
    end
  end

  assign w_req     = (state_reg == LOAD_W);
  assign w_ch      = ch_reg;
  assign win_ready = issue;
  assign conv33_en = issue;
  assign out_we    = calc_valid;
  assign out_addr  = addr_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_conv33_ctrl.sv
// Randomized self-checking bench for conv33_ctrl (5x5x2 and 3x3x1 configs).
module tb_conv33_ctrl;

  localparam int NPIX = 9;
  localparam int NCH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, w_ack = 1'b0, win_valid = 1'b0, calc_valid = 1'b0;
  logic w_req, win_ready, conv33_en, out_we, busy, done;
  logic [7:0]  w_ch;
  logic [15:0] out_addr;

  logic s_start = 1'b0, s_w_ack = 1'b0, s_win_valid = 1'b0, s_calc_valid = 1'b0;
  logic s_w_req, s_win_ready, s_conv33_en, s_out_we, s_busy, s_done;
  logic [7:0]  s_w_ch;
  logic [15:0] s_out_addr;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  conv33_ctrl #(.IMG_W(5), .IMG_H(5), .C_OUT(2), .ADDR_WIDTH(16), .CH_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .w_req(w_req), .w_ch(w_ch), .w_ack(w_ack),
    .win_valid(win_valid), .win_ready(win_ready), .conv33_en(conv33_en),
    .calc_valid(calc_valid), .out_we(out_we), .out_addr(out_addr), .busy(busy), .done(done)
  );

  conv33_ctrl #(.IMG_W(3), .IMG_H(3), .C_OUT(1), .ADDR_WIDTH(16), .CH_WIDTH(8)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .w_req(s_w_req), .w_ch(s_w_ch), .w_ack(s_w_ack),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .conv33_en(s_conv33_en),
    .calc_valid(s_calc_valid), .out_we(s_out_we), .out_addr(s_out_addr), .busy(s_busy),
    .done(s_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // vmode: 0 = win_valid high, 1 = pattern 1,0,0,1, 2 = random (with random acks/starts)
  task automatic run_layer(input int vmode, input int ack_dly, input bit start_in_run,
                           input int rst_issue);
    int cyc = 0, issues = 0, ch_issues = 0, writes = 0, dones = 0;
    int last_issue = -100, req_cnt = 0, done_cyc = -1, exp_ch = -1, dly;
    bit in_run = 0, finished = 0, exp_en;
    logic en_prev = 1'b0, req_prev = 1'b0;
    int exp_q[$];
    dly = ack_dly;
    while (!finished && cyc < 2000) begin
      @(posedge clk); #1;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check_val("idle_busy", busy, 0);
        check_val("idle_done", done, 0);
        finished = 1;
        start = 0; w_ack = 0; win_valid = 0; calc_valid = 0;
        break;
      end
      if (cyc == 0) check_val("pre_start_busy", busy, 0);
      if (cyc == 1) begin
        check_val("start_busy", busy, 1);
        check_val("start_wreq", w_req, 1);
      end
      start = (cyc == 0) || (start_in_run && issues == 3) ||
              (vmode == 2 && cyc > 0 && busy && $urandom_range(0, 7) == 0);
      calc_valid = en_prev;
      if (vmode == 0) win_valid = 1;
      else if (vmode == 1) win_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
      else win_valid = $urandom_range(0, 1) != 0;
      req_cnt = w_req ? req_cnt + 1 : 0;
      if (vmode == 2 && req_cnt == 1) dly = $urandom_range(0, 3);
      w_ack = w_req ? (req_cnt > dly) : (vmode == 2 && $urandom_range(0, 3) == 0);
      if (w_req && !req_prev) begin
        exp_ch++;
        check_val("w_ch_load", w_ch, exp_ch);
        if (exp_ch > 0) check_val("drain_exit_cyc", cyc, last_issue + 2);
        ch_issues = 0;
      end
      #1;
      exp_en = in_run && win_valid;
      check_val("win_ready", win_ready, exp_en);
      check_val("conv33_en", conv33_en, exp_en);
      if (conv33_en) begin
        exp_q.push_back(exp_ch * NPIX + ch_issues);
        ch_issues++;
        issues++;
        last_issue = cyc;
        check_val("w_ch_run", w_ch, exp_ch);
        if (ch_issues == NPIX) in_run = 0;
      end
      if (out_we) begin
        writes++;
        if (exp_q.size() == 0) check_val("spurious_we", 1, 0);
        else check_val("out_addr", out_addr, exp_q.pop_front());
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check_val("done_cyc", cyc, last_issue + 2);
        check_val("done_ch_issues", ch_issues, NPIX);
        check_val("done_chans", exp_ch + 1, NCH);
      end
      if (rst_issue > 0 && issues == rst_issue) begin
        rst = 1; calc_valid = 0; win_valid = 1; start = 0; w_ack = 0;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_wreq", w_req, 0);
        check_val("rst_win_ready", win_ready, 0);
        check_val("rst_en", conv33_en, 0);
        check_val("rst_done", done, 0);
        check_val("rst_we", out_we, 0);
        check_val("rst_addr", out_addr, 0);
        check_val("rst_wch", w_ch, 0);
        @(posedge clk); #1;
        rst = 0; win_valid = 0;
        return;
      end
      if (w_req && w_ack) in_run = 1;
      en_prev = conv33_en;
      req_prev = w_req;
      cyc++;
    end
    check_val("layer_finished", finished, 1);
    check_val("total_writes", writes, NCH * NPIX);
    check_val("total_issues", issues, NCH * NPIX);
    check_val("done_pulses", dones, 1);
    check_val("pending_results", exp_q.size(), 0);
  endtask

  task automatic run_small();
    int cyc = 0, issues = 0, writes = 0, dones = 0, issue_cyc = -100;
    logic en_prev = 1'b0;
    while (cyc < 50 && dones == 0) begin
      @(posedge clk); #1;
      s_start = (cyc == 0);
      s_w_ack = s_w_req;
      s_win_valid = 1;
      s_calc_valid = en_prev;
      #1;
      if (s_conv33_en) begin
        issues++;
        issue_cyc = cyc;
      end
      if (s_out_we) begin
        writes++;
        check_val("small_addr", s_out_addr, 0);
      end
      if (s_done) begin
        dones++;
        check_val("small_done_cyc", cyc, issue_cyc + 2);
      end
      en_prev = s_conv33_en;
      cyc++;
    end
    @(posedge clk); #1;
    s_start = 0; s_w_ack = 0; s_win_valid = 0; s_calc_valid = 0;
    check_val("small_issues", issues, 1);
    check_val("small_writes", writes, 1);
    check_val("small_dones", dones, 1);
    check_val("small_idle", s_busy, 0);
  endtask

  initial begin
    rst = 1;
    win_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_wreq", w_req, 0);
    check_val("reset_win_ready", win_ready, 0);
    check_val("reset_en", conv33_en, 0);
    check_val("reset_done", done, 0);
    check_val("reset_addr", out_addr, 0);
    check_val("reset_wch", w_ch, 0);
    check_val("reset_small_busy", s_busy, 0);
    rst = 0;
    win_valid = 0;
    run_layer(0, 2, 0, -1);
    run_layer(1, 2, 0, -1);
    run_layer(0, 2, 1, -1);
    run_layer(0, 2, 0, NPIX + 5);
    run_layer(0, 2, 0, -1);
    for (int i = 0; i < 4; i++) run_layer(2, 0, 1, -1);
    run_small();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
